pcie_rb_ptr_ctrl: RTL and testbench

- Ring-buffer pointer manager for the PCIe PDU ring written by the DMA stage (pdu_gen inside dma_avlstrm).
- Consumes the DMA stage's per-PDU commit (pcie_rb_update_valid/size) and the host's consumed read pointer.
- Produces the next write base address and ring almost-full back-pressure for the DMA stage.
- Publishes the committed write pointer to the host through a rate-limited, coalescing doorbell.

---
 rtl/pcie_rb_ptr_ctrl.sv | 124 ++++++++++++
 tb/tb_pcie_rb_ptr_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rb_ptr_ctrl.sv
// Ring-buffer pointer manager for the PCIe PDU ring: tracks the writer/host pointers,
// derives fill level and almost-full, flags errors and publishes a rate-limited doorbell.
module pcie_rb_ptr_ctrl #(
  parameter int PDU_AWIDTH   = 12,
  parameter int AF_MARGIN    = 32,
  parameter int DOORBELL_GAP = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pcie_rb_update_valid,
  input  logic [PDU_AWIDTH-1:0] pcie_rb_update_size,
  output logic [PDU_AWIDTH-1:0] pcie_rb_wr_base_addr,
  output logic                  pcie_rb_almost_full,
  input  logic                  host_rd_ptr_valid,
  input  logic [PDU_AWIDTH-1:0] host_rd_ptr,
  input  logic                  ring_clear,
  output logic                  doorbell_valid,
  output logic [PDU_AWIDTH-1:0] doorbell_wr_ptr,
  output logic [PDU_AWIDTH-1:0] fill_level,
  output logic                  overrun_err,
  output logic                  rd_ptr_err
);

  localparam logic [PDU_AWIDTH-1:0] CAP        = '1;
  localparam logic [PDU_AWIDTH:0]   AF_LIMIT   = (PDU_AWIDTH+1)'(AF_MARGIN);
  localparam logic [15:0]           GAP_RELOAD = 16'(DOORBELL_GAP - 1);

  logic [PDU_AWIDTH-1:0] r_wr_ptr;
  logic [PDU_AWIDTH-1:0] r_rd_ptr;
  logic [PDU_AWIDTH-1:0] r_fill_level;
  logic                  r_almost_full;
  logic                  r_doorbell_valid;
  logic [PDU_AWIDTH-1:0] r_doorbell_wr_ptr;
  logic [15:0]           r_gap_cnt;
  logic                  r_dirty;
  logic                  r_overrun_err;
  logic                  r_rd_ptr_err;

  logic [PDU_AWIDTH-1:0] w_used;
  logic [PDU_AWIDTH-1:0] w_free;
  logic [PDU_AWIDTH-1:0] w_host_dist;
  logic                  w_update;
  logic                  w_host_ok;
  logic                  w_pulse;
  logic                  w_overrun;

  // All ring arithmetic is modulo 2^PDU_AWIDTH; natural truncation does the wrap.
  always_comb begin
    w_used      = r_wr_ptr - r_rd_ptr;
    w_free      = CAP - w_used;
    w_host_dist = r_wr_ptr - host_rd_ptr;
    w_update    = pcie_rb_update_valid && (pcie_rb_update_size != '0);
    // Host may only retire data the writer has produced: its distance behind wr must not grow.
    w_host_ok   = (w_host_dist <= w_used);
    w_pulse     = r_dirty && (r_gap_cnt == '0);
    w_overrun   = w_update && (pcie_rb_update_size > w_free);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_fill_level      <= '0;
      r_almost_full     <= 1'b0;
      r_doorbell_valid  <= 1'b0;
      r_doorbell_wr_ptr <= '0;
      r_gap_cnt         <= '0;
      r_dirty           <= 1'b0;
      r_overrun_err     <= 1'b0;
      r_rd_ptr_err      <= 1'b0;
    end else begin
      // Derived status always tracks the pointers one cycle behind, including across a clear.
      r_fill_level  <= w_used;
      r_almost_full <= ({1'b0, w_free} < AF_LIMIT);

      if (ring_clear) begin
        r_wr_ptr         <= '0;
        r_rd_ptr         <= '0;
        r_dirty          <= 1'b0;
        r_gap_cnt        <= '0;
        r_overrun_err    <= 1'b0;
        r_rd_ptr_err     <= 1'b0;
        r_doorbell_valid <= 1'b0;
      end else begin
        r_doorbell_valid <= w_pulse;
        if (w_pulse) begin
          r_doorbell_wr_ptr <= r_wr_ptr;
          r_gap_cnt         <= GAP_RELOAD;
        end else if (r_gap_cnt != '0) begin
          r_gap_cnt <= r_gap_cnt - 16'd1;
        end

        // An update landing in the pulse cycle must survive to the next pulse.
        if (w_update) begin
          r_wr_ptr <= r_wr_ptr + pcie_rb_update_size;
          r_dirty  <= 1'b1;
        end else if (w_pulse) begin
          r_dirty <= 1'b0;
        end

        if (w_overrun) begin
          r_overrun_err <= 1'b1;
        end

        if (host_rd_ptr_valid) begin
          if (w_host_ok) begin
            r_rd_ptr <= host_rd_ptr;
          end else begin
            r_rd_ptr_err <= 1'b1;
          end
        end
      end
    end
  end

  assign pcie_rb_wr_base_addr = r_wr_ptr;
  assign pcie_rb_almost_full  = r_almost_full;
  assign doorbell_valid       = r_doorbell_valid;
  assign doorbell_wr_ptr      = r_doorbell_wr_ptr;
  assign fill_level           = r_fill_level;
  assign overrun_err          = r_overrun_err;
  assign rd_ptr_err           = r_rd_ptr_err;

endmodule

// File: tb/tb_pcie_rb_ptr_ctrl.sv
// Bench for pcie_rb_ptr_ctrl: directed scenarios plus a randomized run against a
// timestamp-based ring model with a doorbell expectation queue.
module tb_pcie_rb_ptr_ctrl;

  localparam int AW   = 12;
  localparam int MASK = (1 << AW) - 1;
  localparam int CAP  = MASK;
  localparam int AF   = 32;
  localparam int GAP  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pcie_rb_update_valid = 1'b0;
  logic [AW-1:0] pcie_rb_update_size = '0;
  logic [AW-1:0] pcie_rb_wr_base_addr;
  logic          pcie_rb_almost_full;
  logic          host_rd_ptr_valid = 1'b0;
  logic [AW-1:0] host_rd_ptr = '0;
  logic          ring_clear = 1'b0;
  logic          doorbell_valid;
  logic [AW-1:0] doorbell_wr_ptr;
  logic [AW-1:0] fill_level;
  logic          overrun_err;
  logic          rd_ptr_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_wr, m_rd, m_fill, m_cyc, m_last_pulse;
  logic m_af, m_pending, m_ovr, m_rderr, m_db;
  logic [AW-1:0] exp_q[$];

  pcie_rb_ptr_ctrl #(.PDU_AWIDTH(AW), .AF_MARGIN(AF), .DOORBELL_GAP(GAP)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pcie_rb_update_valid (pcie_rb_update_valid),
    .pcie_rb_update_size  (pcie_rb_update_size),
    .pcie_rb_wr_base_addr (pcie_rb_wr_base_addr),
    .pcie_rb_almost_full  (pcie_rb_almost_full),
    .host_rd_ptr_valid    (host_rd_ptr_valid),
    .host_rd_ptr          (host_rd_ptr),
    .ring_clear           (ring_clear),
    .doorbell_valid       (doorbell_valid),
    .doorbell_wr_ptr      (doorbell_wr_ptr),
    .fill_level           (fill_level),
    .overrun_err          (overrun_err),
    .rd_ptr_err           (rd_ptr_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_fill = 0; m_af = 1'b0; m_cyc = 0;
    m_last_pulse = -100000; m_pending = 1'b0; m_ovr = 1'b0; m_rderr = 1'b0; m_db = 1'b0;
    exp_q.delete();
  endtask

  // Model: a pulse is due when something is unpublished and GAP cycles have passed since the last one.
  task automatic model_step(input logic uv, input int us, input logic hv, input int hp, input logic clr);
    int used_old;
    int new_wr;
    used_old = (m_wr - m_rd) & MASK;
    m_fill = used_old;
    m_af = ((CAP - used_old) < AF);
    m_db = 1'b0;
    if (clr) begin
      m_wr = 0; m_rd = 0; m_pending = 1'b0; m_ovr = 1'b0; m_rderr = 1'b0;
      m_last_pulse = -100000;
    end else begin
      if (m_pending && (m_cyc - m_last_pulse >= GAP)) begin
        m_db = 1'b1;
        exp_q.push_back(m_wr[AW-1:0]);
        m_last_pulse = m_cyc;
        m_pending = 1'b0;
      end
      new_wr = m_wr;
      if (uv && us != 0) begin
        if (us > CAP - used_old) m_ovr = 1'b1;
        new_wr = (m_wr + us) & MASK;
        m_pending = 1'b1;
      end
      if (hv) begin
        if (((m_wr - hp) & MASK) <= used_old) m_rd = hp;
        else m_rderr = 1'b1;
      end
      m_wr = new_wr;
    end
    m_cyc++;
  endtask

  // Driver: apply inputs for one clock, step the model, return at the falling edge.
  task automatic tick(input logic uv, input int us, input logic hv, input int hp, input logic clr);
    pcie_rb_update_valid = uv;
    pcie_rb_update_size  = us[AW-1:0];
    host_rd_ptr_valid    = hv;
    host_rd_ptr          = hp[AW-1:0];
    ring_clear           = clr;
    @(posedge clk);
    model_step(uv, us, hv, hp, clr);
    @(negedge clk);
    pcie_rb_update_valid = 1'b0;
    pcie_rb_update_size  = '0;
    host_rd_ptr_valid    = 1'b0;
    host_rd_ptr          = '0;
    ring_clear           = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset();
    int db_seen;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (pcie_rb_wr_base_addr !== '0 || fill_level !== '0 || pcie_rb_almost_full !== 1'b0 ||
        doorbell_valid !== 1'b0 || overrun_err !== 1'b0 || rd_ptr_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_values base=%0d fill=%0d af=%0b db=%0b ovr=%0b rderr=%0b expected all 0",
               pcie_rb_wr_base_addr, fill_level, pcie_rb_almost_full, doorbell_valid, overrun_err, rd_ptr_err);
    end
    db_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 0, 1'b0, 0, 1'b0);
      if (doorbell_valid) db_seen++;
    end
    n_checks++;
    if (pcie_rb_wr_base_addr !== '0 || fill_level !== '0 || pcie_rb_almost_full !== 1'b0 || db_seen != 0) begin
      n_errors++;
      $display("FAIL reset_idle base=%0d fill=%0d af=%0b pulses=%0d expected 0/0/0/0",
               pcie_rb_wr_base_addr, fill_level, pcie_rb_almost_full, db_seen);
    end
  endtask

  task automatic test_back_to_back();
    int extra;
    tick(1'b1, 100, 1'b0, 0, 1'b0);
    n_checks++;
    if (pcie_rb_wr_base_addr !== 12'd100 || doorbell_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_first base=%0d db=%0b expected 100/0", pcie_rb_wr_base_addr, doorbell_valid);
    end
    tick(1'b1, 200, 1'b0, 0, 1'b0);
    n_checks++;
    if (pcie_rb_wr_base_addr !== 12'd300 || doorbell_valid !== 1'b1 || doorbell_wr_ptr !== 12'd100) begin
      n_errors++;
      $display("FAIL b2b_pulse1 base=%0d db=%0b dbptr=%0d expected 300/1/100",
               pcie_rb_wr_base_addr, doorbell_valid, doorbell_wr_ptr);
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 0, 1'b0, 0, 1'b0);
      if (doorbell_valid) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_errors++;
      $display("FAIL b2b_gap pulses_in_gap=%0d expected 0", extra);
    end
    tick(1'b0, 0, 1'b0, 0, 1'b0);
    n_checks++;
    if (doorbell_valid !== 1'b1 || doorbell_wr_ptr !== 12'd300) begin
      n_errors++;
      $display("FAIL b2b_pulse2 db=%0b dbptr=%0d expected 1/300", doorbell_valid, doorbell_wr_ptr);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 0, 1'b0, 0, 1'b0);
      if (doorbell_valid) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_errors++;
      $display("FAIL b2b_after extra_pulses=%0d expected 0", extra);
    end
  endtask

  task automatic test_almost_full();
    tick(1'b0, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 126; i++) tick(1'b1, 32, 1'b0, 0, 1'b0);
    tick(1'b1, 31, 1'b0, 0, 1'b0);
    tick(1'b0, 0, 1'b0, 0, 1'b0);
    n_checks++;
    if (pcie_rb_wr_base_addr !== 12'd4063 || fill_level !== 12'd4063 || pcie_rb_almost_full !== 1'b0) begin
      n_errors++;
      $display("FAIL af_free32 base=%0d fill=%0d af=%0b expected 4063/4063/0",
               pcie_rb_wr_base_addr, fill_level, pcie_rb_almost_full);
    end
    tick(1'b1, 1, 1'b0, 0, 1'b0);
    n_checks++;
    if (pcie_rb_wr_base_addr !== 12'd4064 || pcie_rb_almost_full !== 1'b0) begin
      n_errors++;
      $display("FAIL af_latency base=%0d af=%0b expected 4064/0", pcie_rb_wr_base_addr, pcie_rb_almost_full);
    end
    tick(1'b0, 0, 1'b0, 0, 1'b0);
    n_checks++;
    if (pcie_rb_almost_full !== 1'b1) begin
      n_errors++;
      $display("FAIL af_free31 af=%0b expected 1", pcie_rb_almost_full);
    end
    tick(1'b0, 0, 1'b1, 1000, 1'b0);
    tick(1'b0, 0, 1'b0, 0, 1'b0);
    n_checks++;
    if (pcie_rb_almost_full !== 1'b0 || fill_level !== 12'd3064 || overrun_err !== 1'b0 || rd_ptr_err !== 1'b0) begin
      n_errors++;
      $display("FAIL af_release af=%0b fill=%0d ovr=%0b rderr=%0b expected 0/3064/0/0",
               pcie_rb_almost_full, fill_level, overrun_err, rd_ptr_err);
    end
  endtask

  task automatic test_wrap();
    tick(1'b0, 0, 1'b0, 0, 1'b1);
    tick(1'b1, 4000, 1'b0, 0, 1'b0);
    tick(1'b0, 0, 1'b1, 4000, 1'b0);
    tick(1'b1, 200, 1'b0, 0, 1'b0);
    tick(1'b0, 0, 1'b0, 0, 1'b0);
    n_checks++;
    if (pcie_rb_wr_base_addr !== 12'd104 || fill_level !== 12'd200 || overrun_err !== 1'b0 || rd_ptr_err !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap base=%0d fill=%0d ovr=%0b rderr=%0b expected 104/200/0/0",
               pcie_rb_wr_base_addr, fill_level, overrun_err, rd_ptr_err);
    end
  endtask

  task automatic test_errors();
    tick(1'b0, 0, 1'b0, 0, 1'b1);
    tick(1'b1, 4085, 1'b0, 0, 1'b0);
    tick(1'b1, 20, 1'b0, 0, 1'b0);
    n_checks++;
    if (overrun_err !== 1'b1 || pcie_rb_wr_base_addr !== 12'd9 || rd_ptr_err !== 1'b0) begin
      n_errors++;
      $display("FAIL overrun ovr=%0b base=%0d rderr=%0b expected 1/9/0", overrun_err, pcie_rb_wr_base_addr, rd_ptr_err);
    end
    tick(1'b0, 0, 1'b0, 0, 1'b1);
    tick(1'b1, 500, 1'b0, 0, 1'b0);
    tick(1'b0, 0, 1'b1, 400, 1'b0);
    tick(1'b0, 0, 1'b1, 600, 1'b0);
    tick(1'b0, 0, 1'b0, 0, 1'b0);
    n_checks++;
    if (rd_ptr_err !== 1'b1 || fill_level !== 12'd100 || overrun_err !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_ptr_pass rderr=%0b fill=%0d ovr=%0b expected 1/100/0", rd_ptr_err, fill_level, overrun_err);
    end
  endtask

  task automatic test_clear();
    idle(20);
    tick(1'b1, 1, 1'b0, 0, 1'b0);
    tick(1'b1, 50, 1'b1, 450, 1'b1);
    n_checks++;
    if (pcie_rb_wr_base_addr !== '0 || overrun_err !== 1'b0 || rd_ptr_err !== 1'b0 || doorbell_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_cycle base=%0d ovr=%0b rderr=%0b db=%0b expected 0/0/0/0",
               pcie_rb_wr_base_addr, overrun_err, rd_ptr_err, doorbell_valid);
    end
    tick(1'b0, 0, 1'b0, 0, 1'b0);
    n_checks++;
    if (fill_level !== '0 || pcie_rb_almost_full !== 1'b0 || doorbell_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_after fill=%0d af=%0b db=%0b expected 0/0/0", fill_level, pcie_rb_almost_full, doorbell_valid);
    end
  endtask

  task automatic test_random();
    logic uv, hv, clr;
    int us, hp, used;
    int bad;
    exp_q.delete();
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      uv  = ($urandom_range(0, 99) < 50);
      us  = ($urandom_range(0, 99) < 5) ? $urandom_range(0, MASK) : $urandom_range(0, 48);
      hv  = ($urandom_range(0, 99) < 25);
      used = (m_wr - m_rd) & MASK;
      hp  = ($urandom_range(0, 99) < 75) ? ((m_rd + $urandom_range(0, used)) & MASK) : $urandom_range(0, MASK);
      clr = ($urandom_range(0, 199) == 0);
      tick(uv, us, hv, hp, clr);
      n_checks++;
      if (pcie_rb_wr_base_addr !== m_wr[AW-1:0] || fill_level !== m_fill[AW-1:0] ||
          pcie_rb_almost_full !== m_af || overrun_err !== m_ovr || rd_ptr_err !== m_rderr ||
          doorbell_valid !== m_db) begin
        n_errors++;
        if (bad < 10)
          $display("FAIL rand_state cyc=%0d got base=%0d fill=%0d af=%0b ovr=%0b rderr=%0b db=%0b want %0d/%0d/%0b/%0b/%0b/%0b",
                   i, pcie_rb_wr_base_addr, fill_level, pcie_rb_almost_full, overrun_err, rd_ptr_err, doorbell_valid,
                   m_wr, m_fill, m_af, m_ovr, m_rderr, m_db);
        bad++;
      end
      if (doorbell_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL rand_doorbell cyc=%0d unexpected pulse ptr=%0d expected none", i, doorbell_wr_ptr);
        end else begin
          logic [AW-1:0] exp_ptr;
          exp_ptr = exp_q.pop_front();
          if (doorbell_wr_ptr !== exp_ptr) begin
            n_errors++;
            $display("FAIL rand_doorbell cyc=%0d ptr=%0d expected %0d", i, doorbell_wr_ptr, exp_ptr);
          end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL rand_doorbell_missing outstanding=%0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_almost_full();
    test_wrap();
    test_errors();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
